// File: rtl/instr_encoder_pkg.sv
// Shared instruction-format definitions: opcodes, ALU selectors, field positions
// and request op encodings, used by the encoder and the processor decode logic.
package instr_encoder_pkg;

   typedef enum logic [1:0] {
      OP_ADD     = 2'd0,
      OP_SUB     = 2'd1,
      OP_ADDI    = 2'd2,
      OP_ILLEGAL = 2'd3
   } req_op_e;

   localparam logic [4:0] OPC_RTYPE = 5'b00000;
   localparam logic [4:0] OPC_ADDI  = 5'b00101;
   localparam logic [4:0] ALU_ADD   = 5'b00000;
   localparam logic [4:0] ALU_SUB   = 5'b00001;

   localparam int OPC_LSB   = 27;
   localparam int RD_LSB    = 22;
   localparam int RS_LSB    = 17;
   localparam int RT_LSB    = 12;
   localparam int SHAMT_LSB = 7;
   localparam int ALUOP_LSB = 2;
   localparam int IMM_W     = 17;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns a request into its 32-bit machine word and
// flags whether the op is one the encoder may emit.
module instr_pack
   import instr_encoder_pkg::*;
(
   input  logic [1:0]       op,
   input  logic [4:0]       rd,
   input  logic [4:0]       rs,
   input  logic [4:0]       rt,
   input  logic [IMM_W-1:0] imm,
   output logic [31:0]      word,
   output logic             legal
);

   // Shamt and the low two bits stay zero from the default for R-type words.
   always_comb begin
      word              = '0;
      legal             = 1'b1;
      word[RD_LSB +: 5] = rd;
      word[RS_LSB +: 5] = rs;
      case (req_op_e'(op))
         OP_ADD: begin
            word[OPC_LSB +: 5]   = OPC_RTYPE;
            word[RT_LSB +: 5]    = rt;
            word[ALUOP_LSB +: 5] = ALU_ADD;
         end
         OP_SUB: begin
            word[OPC_LSB +: 5]   = OPC_RTYPE;
            word[RT_LSB +: 5]    = rt;
            word[ALUOP_LSB +: 5] = ALU_SUB;
         end
         OP_ADDI: begin
            word[OPC_LSB +: 5]   = OPC_ADDI;
            word[IMM_W-1:0]      = imm;
         end
         default: begin
            word  = '0;
            legal = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Single-stage encoder: packs accepted requests into instruction words and pairs
// each one with a sequential instruction-memory write address.
module instr_encoder
   import instr_encoder_pkg::*;
#(
   parameter int ADDR_W = 12
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [1:0]        req_op,
   input  logic [4:0]        req_rd,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [IMM_W-1:0]  req_imm,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_word,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err,
   output logic              wrapped
);

   logic [31:0]       packed_word;
   logic              packed_legal;
   logic              req_fire;
   logic              out_fire;
   logic [ADDR_W-1:0] addr_cnt;

   instr_pack u_pack (
      .op    (req_op),
      .rd    (req_rd),
      .rs    (req_rs),
      .rt    (req_rt),
      .imm   (req_imm),
      .word  (packed_word),
      .legal (packed_legal)
   );

   assign req_ready = !out_valid || out_ready;
   assign req_fire  = req_valid && req_ready;
   assign out_fire  = out_valid && out_ready;
   assign out_addr  = addr_cnt;

   // The address only moves on an output transfer, so a stalled word keeps its address.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         out_valid <= 1'b0;
         out_word  <= '0;
         addr_cnt  <= '0;
         err       <= 1'b0;
         wrapped   <= 1'b0;
      end else begin
         if (out_fire) begin
            addr_cnt <= addr_cnt + 1'b1;
            if (addr_cnt == {ADDR_W{1'b1}}) begin
               wrapped <= 1'b1;
            end
         end
         if (req_fire && packed_legal) begin
            out_valid <= 1'b1;
            out_word  <= packed_word;
         end else if (out_fire) begin
            out_valid <= 1'b0;
         end
         if (req_fire && !packed_legal) begin
            err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench: directed vectors with literal expectations plus a
// transaction-level model checked every cycle on a default and a 2-bit-address DUT.
module tb_instr_encoder;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic [1:0]  req_op = 2'd0;
   logic [4:0]  req_rd = '0, req_rs = '0, req_rt = '0;
   logic [16:0] req_imm = '0;
   logic        out_ready = 1'b0;

   logic        req_ready, out_valid, err, wrapped;
   logic [31:0] out_word;
   logic [11:0] out_addr;
   logic        req_ready_s, out_valid_s, err_s, wrapped_s;
   logic [31:0] out_word_s;
   logic [1:0]  out_addr_s;

   int check_count = 0;
   int pass_count  = 0;

   always #5 clock = ~clock;

   instr_encoder dut (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
      .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word), .out_addr(out_addr),
      .err(err), .wrapped(wrapped)
   );

   instr_encoder #(.ADDR_W(2)) dut_small (
      .clock(clock), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready_s),
      .req_op(req_op), .req_rd(req_rd), .req_rs(req_rs), .req_rt(req_rt), .req_imm(req_imm),
      .out_valid(out_valid_s), .out_ready(out_ready), .out_word(out_word_s), .out_addr(out_addr_s),
      .err(err_s), .wrapped(wrapped_s)
   );

   function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
      check_count++;
      if (act === exp) pass_count++;
      else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
   endfunction

   // Instruction word computed straight from the field layout with plain arithmetic.
   function automatic logic [31:0] expWord(int op, int rd, int rs, int rt, int imm);
      int w;
      w = rd * (2 ** 22) + rs * (2 ** 17);
      if (op == 2) w = w + 5 * (2 ** 27) + imm;
      else         w = w + rt * (2 ** 12) + op * 4;
      return 32'(w);
   endfunction

   logic [31:0] model_q[$];
   int          model_xfers = 0;
   bit          model_err   = 0;
   bit          armed       = 0;
   bit          m_out_fire, m_req_fire, m_valid;

   // Outputs are checked against the model, then the model advances to the next edge.
   always @(negedge clock) begin
      if (armed) begin
         m_valid = (model_q.size() != 0);
         checkOutput("out_valid", 32'(out_valid), 32'(m_valid));
         checkOutput("out_valid_small", 32'(out_valid_s), 32'(m_valid));
         checkOutput("req_ready", 32'(req_ready), 32'(!m_valid || out_ready));
         checkOutput("req_ready_small", 32'(req_ready_s), 32'(!m_valid || out_ready));
         checkOutput("err", 32'(err), 32'(model_err));
         checkOutput("err_small", 32'(err_s), 32'(model_err));
         checkOutput("wrapped", 32'(wrapped), 32'(model_xfers >= 4096));
         checkOutput("wrapped_small", 32'(wrapped_s), 32'(model_xfers >= 4));
         if (m_valid) begin
            checkOutput("out_word", out_word, model_q[0]);
            checkOutput("out_word_small", out_word_s, model_q[0]);
            checkOutput("out_addr", 32'(out_addr), 32'(model_xfers % 4096));
            checkOutput("out_addr_small", 32'(out_addr_s), 32'(model_xfers % 4));
         end
      end
      if (!reset_n) begin
         model_q.delete();
         model_xfers = 0;
         model_err   = 0;
         armed       = 1;
      end else if (armed) begin
         m_out_fire = (model_q.size() != 0) && out_ready;
         m_req_fire = req_valid && ((model_q.size() == 0) || out_ready);
         if (m_out_fire) begin
            void'(model_q.pop_front());
            model_xfers++;
         end
         if (m_req_fire) begin
            if (req_op == 2'd3) model_err = 1;
            else model_q.push_back(expWord(int'(req_op), int'(req_rd), int'(req_rs),
                                           int'(req_rt), int'(req_imm)));
         end
      end
   end

   task automatic applyStimulus(input bit v, input logic [1:0] op, input logic [4:0] rd,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [16:0] imm, input bit ordy);
      req_valid = v;
      req_op    = op;
      req_rd    = rd;
      req_rs    = rs;
      req_rt    = rt;
      req_imm   = imm;
      out_ready = ordy;
      @(posedge clock);
      #1;
   endtask

   initial begin
      // Reset values
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("rst_out_valid", 32'(out_valid), 0);
      checkOutput("rst_out_word", out_word, 0);
      checkOutput("rst_out_addr", 32'(out_addr), 0);
      checkOutput("rst_err", 32'(err), 0);
      checkOutput("rst_wrapped", 32'(wrapped), 0);
      reset_n = 1'b1;

      // Illegal op between two legal requests: no gap word
      applyStimulus(1, 0, 1, 2, 3, 0, 1);
      checkOutput("ill_first_word", out_word, 32'h00443000);
      checkOutput("ill_first_addr", 32'(out_addr), 0);
      applyStimulus(1, 3, 9, 9, 9, 0, 1);
      checkOutput("ill_gap_valid", 32'(out_valid), 0);
      checkOutput("ill_err", 32'(err), 1);
      applyStimulus(1, 1, 1, 2, 3, 0, 1);
      checkOutput("ill_second_word", out_word, 32'h00443004);
      checkOutput("ill_second_addr", 32'(out_addr), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("ill_err_sticky", 32'(err), 1);

      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      reset_n = 1'b1;

      // Streaming encodes with out_ready held high
      applyStimulus(1, 0, 1, 2, 3, 0, 1);
      checkOutput("add_word", out_word, 32'h00443000);
      checkOutput("add_addr", 32'(out_addr), 0);
      checkOutput("add_valid", 32'(out_valid), 1);
      applyStimulus(1, 1, 1, 2, 3, 0, 1);
      checkOutput("sub_word", out_word, 32'h00443004);
      checkOutput("sub_addr", 32'(out_addr), 1);
      applyStimulus(1, 2, 5, 0, 31, 17'h1FFFF, 1);
      checkOutput("addi_word", out_word, 32'h2941FFFF);
      checkOutput("addi_addr", 32'(out_addr), 2);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("drain_valid", 32'(out_valid), 0);

      // Backpressure: held word, stalled request, then back-to-back release
      applyStimulus(1, 0, 7, 1, 2, 0, 0);
      checkOutput("bp_word", out_word, 32'h01C22000);
      checkOutput("bp_addr_small", 32'(out_addr_s), 3);
      checkOutput("bp_wrapped_small", 32'(wrapped_s), 0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1, 1, 2, 3, 4, 0, 0);
         checkOutput("bp_req_ready", 32'(req_ready), 0);
         checkOutput("bp_hold_word", out_word, 32'h01C22000);
         checkOutput("bp_hold_addr", 32'(out_addr), 3);
      end
      applyStimulus(1, 1, 2, 3, 4, 0, 1);
      checkOutput("b2b_word", out_word, 32'h00864004);
      checkOutput("b2b_addr", 32'(out_addr), 4);
      checkOutput("b2b_valid", 32'(out_valid), 1);
      checkOutput("wrap_addr_small", 32'(out_addr_s), 0);
      checkOutput("wrap_flag_small", 32'(wrapped_s), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 1);
      checkOutput("wrap_sticky_small", 32'(wrapped_s), 1);

      // Reset while a word is held under backpressure
      applyStimulus(1, 3, 0, 0, 0, 0, 1);
      applyStimulus(1, 0, 1, 2, 3, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("pre_rst_valid", 32'(out_valid), 1);
      reset_n = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("midrst_valid", 32'(out_valid), 0);
      checkOutput("midrst_addr", 32'(out_addr), 0);
      checkOutput("midrst_err", 32'(err), 0);
      checkOutput("midrst_wrapped_small", 32'(wrapped_s), 0);
      reset_n = 1'b1;
      #1;
      checkOutput("midrst_req_ready", 32'(req_ready), 1);
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("post_rst_req_ready", 32'(req_ready), 1);

      @(negedge clock);
      #1;
      $display("[TB] %0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 12: width of the emitted instruction-memory write address.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset_n  input  1  synchronous, active-low reset.
REQ-004 req_valid  input  1  encode request present.
REQ-005 req_ready  output  1  block accepts request this cycle.
REQ-006 req_op  input  2  operation: 0=add, 1=sub, 2=addi, 3=illegal.
REQ-007 req_rd, req_rs, req_rt  input  5 each  register fields; rt ignored for addi.
REQ-008 req_imm  input  17  immediate; used for addi only.
REQ-009 out_valid  output  1  encoded word held for the memory writer.
REQ-010 out_ready  input  1  memory writer accepts the word this cycle.
REQ-011 out_word  output  32  encoded instruction.
REQ-012 out_addr  output  ADDR_W  write address paired with out_word.
REQ-013 err  output  1  sticky: an illegal op was received.
REQ-014 wrapped  output  1  sticky: address counter wrapped past its maximum.

Function
REQ-015 R-type (add/sub) word SHALL be: opcode[31:27]=00000, rd[26:22], rs[21:17], rt[16:12], shamt[11:7]=0, aluop[6:2] (add=00000, sub=00001), [1:0]=00.
REQ-016 I-type (addi) word SHALL be: opcode[31:27]=00101, rd[26:22], rs[21:17], imm[16:0].
REQ-017 Request handshake: transfer occurs when req_valid && req_ready; req_ready = !out_valid || out_ready (single-register pipeline stage, no bubble under continuous flow).
REQ-018 A legal accepted request SHALL appear on out_word/out_valid in the cycle after acceptance (latency 1).
REQ-019 out_word and out_addr SHALL hold stable while out_valid && !out_ready.
REQ-020 Output handshake: transfer occurs when out_valid && out_ready; out_valid clears the next cycle unless a new legal request is accepted in the same cycle.
REQ-021 Simultaneous output transfer and request acceptance SHALL load the new word in the same cycle; out_valid stays 1.
REQ-022 An internal address counter SHALL be presented on out_addr and increment by 1 on each output transfer; it wraps from 2^ADDR_W-1 to 0 and sets wrapped.
REQ-023 An illegal op (3) SHALL be accepted under the normal handshake, SHALL NOT produce an output word or advance the counter, and SHALL set err.
REQ-024 err and wrapped SHALL remain set until reset.

Reset
REQ-025 While reset_n=0 at a clock edge: out_valid=0, out_word=0, address counter=0, err=0, wrapped=0.
REQ-026 Reset mid-operation SHALL discard any held word without an output transfer; req_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-027 Opcode constants (00000, 00101) and aluop constants (add=00000, sub=00001), field bit positions, and req_op encodings SHALL reside in a shared package used by both this encoder and the processor decode logic.
REQ-028 One sub-module, instr_pack (purely combinational field packer: op, rd, rs, rt, imm -> 32-bit word, legal flag), SHALL be instantiated.

Verification
REQ-029 add rd=1 rs=2 rt=3, out_ready=1 -> next cycle out_word=0x00443000, out_addr=0, out_valid=1.
REQ-030 sub rd=1 rs=2 rt=3 -> out_word=0x00443004; addi rd=5 rs=0 imm=0x1FFFF -> out_word=0x2941FFFF.
REQ-031 Backpressure: out_ready=0 for 3 cycles with word held -> req_ready=0, out_word/out_addr unchanged; one cycle of out_ready=1 with a new request pending -> back-to-back words at consecutive addresses.
REQ-032 req_op=3 between two legal requests -> err=1, the two legal words emitted at addresses 0 and 1, no gap word.
REQ-033 ADDR_W=2, 5 legal transfers -> out_addr sequence 0,1,2,3,0; wrapped=1 after the fourth transfer.
REQ-034 reset_n=0 while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_addr=0, err=0, wrapped=0, req_ready=1.
